// File: rtl/scan_mux_n_if.sv
// Channel-selector bus: control, flattened channel data and selected output.
// The bench drives through the master modport; scan_mux_n takes the slave side.
interface scan_mux_n_if #(
    parameter int W    = 5,
    parameter int N    = 6,
    parameter int SELW = 3,
    parameter int DWW  = 16
);
    logic            en;
    logic            mode;
    logic [SELW-1:0] sel_in;
    logic [DWW-1:0]  dwell;
    logic [N*W-1:0]  din;
    logic [W-1:0]    dout;
    logic [SELW-1:0] sel_out;
    logic            valid;
    logic            wrap;

    modport master (
        output en, mode, sel_in, dwell, din,
        input  dout, sel_out, valid, wrap
    );

    modport slave (
        input  en, mode, sel_in, dwell, din,
        output dout, sel_out, valid, wrap
    );
endinterface

// File: rtl/scan_mux_n.sv
// Registered N-to-1 selector of W-bit codes.
// Supports a manual select mode and a round-robin auto-scan mode with a programmable dwell.
module scan_mux_n #(
    parameter int W    = 5,
    parameter int N    = 6,
    parameter int SELW = 3,
    parameter int DWW  = 16
) (
    input logic        clk,
    input logic        rst,
    scan_mux_n_if.slave bus
);

    logic [W-1:0]    dout_q, dout_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic            valid_q, valid_d;
    logic            wrap_q, wrap_d;
    logic [DWW-1:0]  cnt_q, cnt_d;
    logic [SELW-1:0] base;

    // Explicit compare chain keeps an out-of-range select from indexing past din.
    function automatic logic [W-1:0] pick(
        input logic [SELW-1:0] s,
        input logic [N*W-1:0]  d
    );
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (s == SELW'(k)) r = d[k*W +: W];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            dout_q  <= dout_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        dout_d  = dout_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        base    = valid_q ? sel_q : '0;
        if (bus.en) begin
            if (!bus.mode) begin
                cnt_d = '0;
                if (int'(bus.sel_in) < N) begin
                    sel_d   = bus.sel_in;
                    dout_d  = pick(bus.sel_in, bus.din);
                    valid_d = 1'b1;
                end
            end else begin
                if (cnt_q < bus.dwell) begin
                    cnt_d = cnt_q + DWW'(1);
                    sel_d = base;
                end else begin
                    cnt_d = '0;
                    if (base == SELW'(N - 1)) begin
                        sel_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        sel_d = base + SELW'(1);
                    end
                end
                dout_d  = pick(sel_d, bus.din);
                valid_d = 1'b1;
            end
        end
    end

    assign bus.dout    = dout_q;
    assign bus.sel_out = sel_q;
    assign bus.valid   = valid_q;
    assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_scan_mux_n.sv
// Directed bench for scan_mux_n: reset, manual select, auto scan,
// enable freeze and mid-scan reset, checked with immediate assertions.
module tb_scan_mux_n;
    localparam int W    = 5;
    localparam int N    = 6;
    localparam int SELW = 3;
    localparam int DWW  = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_wrap;

    scan_mux_n_if #(.W(W), .N(N), .SELW(SELW), .DWW(DWW)) bus ();

    scan_mux_n #(.W(W), .N(N), .SELW(SELW), .DWW(DWW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int k, input int v);
        bus.din[k*W +: W] = W'(v);
    endtask

    initial begin
        rst        = 1'b1;
        bus.en     = 1'b1;
        bus.mode   = 1'b0;
        bus.sel_in = '0;
        bus.dwell  = '0;
        bus.din    = '0;
        for (int k = 0; k < N; k++) set_ch(k, $urandom_range(31));

        // 1 reset
        tick();
        tick();
        check("rst_dout", int'(bus.dout), 0);
        check("rst_sel", int'(bus.sel_out), 0);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_wrap", int'(bus.wrap), 0);

        // 2 manual sweep, ch k = k+3
        for (int k = 0; k < N; k++) set_ch(k, k + 3);
        rst = 1'b0;
        for (int s = 0; s < N; s++) begin
            bus.sel_in = SELW'(s);
            tick();
            check("man_dout", int'(bus.dout), s + 3);
            check("man_sel", int'(bus.sel_out), s);
            check("man_valid", int'(bus.valid), 1);
            check("man_wrap", int'(bus.wrap), 0);
        end

        // 3 out-of-range selects hold
        bus.sel_in = 3'd2;
        tick();
        check("oor_pre", int'(bus.dout), 5);
        for (int s = 6; s < 8; s++) begin
            bus.sel_in = SELW'(s);
            tick();
            check("oor_dout", int'(bus.dout), 5);
            check("oor_sel", int'(bus.sel_out), 2);
            check("oor_valid", int'(bus.valid), 1);
        end

        // 4 auto, dwell=2, from reset
        rst = 1'b1;
        tick();
        check("r4_sel", int'(bus.sel_out), 0);
        rst       = 1'b0;
        bus.mode  = 1'b1;
        bus.dwell = DWW'(2);
        n_wrap    = 0;
        for (int i = 1; i <= 36; i++) begin
            tick();
            check("auto_sel", int'(bus.sel_out), (i / 3) % N);
            check("auto_dout", int'(bus.dout), (i / 3) % N + 3);
            check("auto_wrap", int'(bus.wrap), (i % 18 == 0) ? 1 : 0);
            if (bus.wrap) n_wrap++;
        end
        check("wrap_count", n_wrap, 2);

        // 5 auto dwell=0 with enable freeze
        bus.dwell = '0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("d0_sel", int'(bus.sel_out), i);
        end
        bus.en = 1'b0;
        set_ch(3, 31);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_sel", int'(bus.sel_out), 3);
            check("frz_dout", int'(bus.dout), 6);
            check("frz_wrap", int'(bus.wrap), 0);
        end
        set_ch(3, 6);
        bus.en = 1'b1;
        tick();
        check("res_sel", int'(bus.sel_out), 4);
        check("res_dout", int'(bus.dout), 7);
        tick();
        check("res_sel5", int'(bus.sel_out), 5);
        tick();
        check("res_wrap_sel", int'(bus.sel_out), 0);
        check("res_wrap", int'(bus.wrap), 1);
        bus.en = 1'b0;
        tick();
        check("frz_wrap_clr", int'(bus.wrap), 0);
        check("frz_sel0", int'(bus.sel_out), 0);

        // 6 reach ch4 with dwell_cnt=1, then reset mid-scan
        bus.en    = 1'b1;
        bus.dwell = DWW'(2);
        for (int i = 0; i < 13; i++) tick();
        check("pre_rst_sel", int'(bus.sel_out), 4);
        rst = 1'b1;
        tick();
        check("mid_rst_sel", int'(bus.sel_out), 0);
        check("mid_rst_dout", int'(bus.dout), 0);
        check("mid_rst_valid", int'(bus.valid), 0);
        rst = 1'b0;
        tick();
        check("post_rst_sel", int'(bus.sel_out), 0);
        check("post_rst_dout", int'(bus.dout), 3);
        check("post_rst_valid", int'(bus.valid), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
